// File: rtl/vga_pkg.sv
// Shared VGA timing constants and vertical FSM encoding.
// Used by both the horizontal and vertical sync blocks.
package vga_pkg;

  localparam int H_TOTAL_DEF  = 1600;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 29;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_TOTAL_DEF  = V_SYNC_DEF + V_BP_DEF
                              + V_ACTIVE_DEF + V_FP_DEF;

  localparam int VL_W = 10;
  localparam int AL_W = 9;
  localparam int FC_W = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SYNC        = 3'd1,
    BACK_PORCH  = 3'd2,
    ACTIVE      = 3'd3,
    FRONT_PORCH = 3'd4
  } vstate_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_vsync_ctrl_if.sv
// Control/status bundle of the vertical sync block.
// The driver of enable/pause_req takes the master side.
interface vga_vsync_ctrl_if;
  import vga_pkg::*;

  logic            enable;
  logic            pause_req;
  logic            v_sync;
  logic            h_sync_en;
  logic            line_start;
  logic            frame_start;
  logic [AL_W-1:0] active_line;
  logic [FC_W-1:0] frame_count;
  logic            paused;

  modport master (
    output enable, pause_req,
    input  v_sync, h_sync_en, line_start,
    input  frame_start, active_line,
    input  frame_count, paused
  );

  modport slave (
    input  enable, pause_req,
    output v_sync, h_sync_en, line_start,
    output frame_start, active_line,
    output frame_count, paused
  );

endinterface

// File: rtl/vga_h_counter.sv
// Free-running pixel counter 0..H_TOTAL-1.
// wrap_o is high on the cycle whose edge closes the line.
module vga_h_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic wrap_o
);

  localparam int HW = cnt_w(H_TOTAL);

  logic [HW-1:0] h_q, h_d;

  assign wrap_o = (h_q == HW'(H_TOTAL - 1));

  always_comb begin
    h_d = h_q + 1'b1;
    if (wrap_o)
      h_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      h_q <= '0;
    else
      h_q <= h_d;
  end

endmodule

// File: rtl/vga_vsync_ctrl.sv
// Vertical sync FSM; steps one line per horizontal wrap.
// All outputs are registered and move on line boundaries.
module vga_vsync_ctrl
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF
) (
  input logic              clk,
  input logic              reset,
  vga_vsync_ctrl_if.slave  bus
);

  vstate_e         state_q;
  logic [VL_W-1:0] v_line_q;
  logic            v_sync_q;
  logic            h_sync_en_q;
  logic            line_start_q;
  logic            frame_start_q;
  logic [AL_W-1:0] active_line_q;
  logic [FC_W-1:0] frame_count_q;
  logic            paused_q;

  logic            wrap;
  logic [VL_W-1:0] len_m1;
  logic            last;

  vga_h_counter #(
    .H_TOTAL (H_TOTAL)
  ) u_hcnt (
    .clk    (clk),
    .reset  (reset),
    .wrap_o (wrap)
  );

  always_comb begin
    len_m1 = '0;
    unique case (state_q)
      SYNC:        len_m1 = VL_W'(V_SYNC - 1);
      BACK_PORCH:  len_m1 = VL_W'(V_BP - 1);
      ACTIVE:      len_m1 = VL_W'(V_ACTIVE - 1);
      FRONT_PORCH: len_m1 = VL_W'(V_FP - 1);
      default:     len_m1 = '0;
    endcase
  end

  assign last = (v_line_q == len_m1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      v_line_q      <= '0;
      v_sync_q      <= 1'b1;
      h_sync_en_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      active_line_q <= '0;
      frame_count_q <= '0;
      paused_q      <= 1'b1;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (wrap) begin
        v_line_q <= v_line_q + 1'b1;
        // A frame that reached its last porch line counts even if halted
        if (state_q == FRONT_PORCH && last)
          frame_count_q <= frame_count_q + 1'b1;
        if (!bus.enable) begin
          state_q       <= IDLE;
          v_line_q      <= '0;
          v_sync_q      <= 1'b1;
          h_sync_en_q   <= 1'b0;
          active_line_q <= '0;
          paused_q      <= 1'b1;
        end else begin
          unique case (state_q)
            IDLE: begin
              v_line_q <= '0;
              if (!bus.pause_req) begin
                state_q       <= SYNC;
                v_sync_q      <= 1'b0;
                frame_start_q <= 1'b1;
                paused_q      <= 1'b0;
              end
            end
            SYNC: if (last) begin
              state_q  <= BACK_PORCH;
              v_line_q <= '0;
              v_sync_q <= 1'b1;
            end
            BACK_PORCH: if (last) begin
              state_q       <= ACTIVE;
              v_line_q      <= '0;
              h_sync_en_q   <= 1'b1;
              line_start_q  <= 1'b1;
              active_line_q <= '0;
            end
            ACTIVE: begin
              if (last) begin
                state_q       <= FRONT_PORCH;
                v_line_q      <= '0;
                h_sync_en_q   <= 1'b0;
                active_line_q <= '0;
              end else begin
                line_start_q  <= 1'b1;
                active_line_q <= active_line_q + 1'b1;
              end
            end
            FRONT_PORCH: if (last) begin
              v_line_q <= '0;
              if (bus.pause_req) begin
                state_q  <= IDLE;
                paused_q <= 1'b1;
              end else begin
                state_q       <= SYNC;
                v_sync_q      <= 1'b0;
                frame_start_q <= 1'b1;
              end
            end
            default: begin
              state_q  <= IDLE;
              v_line_q <= '0;
              paused_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.v_sync      = v_sync_q;
  assign bus.h_sync_en   = h_sync_en_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active_line = active_line_q;
  assign bus.frame_count = frame_count_q;
  assign bus.paused      = paused_q;

endmodule

// File: tb/tb_vga_vsync_ctrl.sv
// Directed bench for vga_vsync_ctrl on a shrunk raster.
// 8 clocks/line, 2+3+4+2 lines: 88 clocks per frame.
module tb_vga_vsync_ctrl;

  localparam int HT  = 8;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_vsync_ctrl_if bus ();

  vga_vsync_ctrl #(
    .H_TOTAL  (HT),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int t      = 0;
  int cyc, ls_cnt, hs_cnt, fs_cnt, vs_cnt;
  int hs_first, al_max;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
  endtask

  task automatic clr();
    cyc = 0; ls_cnt = 0; hs_cnt = 0;
    fs_cnt = 0; vs_cnt = 0;
    hs_first = 0; al_max = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    cyc++;
    if (bus.line_start) ls_cnt++;
    if (bus.frame_start) fs_cnt++;
    if (!bus.v_sync) vs_cnt++;
    if (bus.h_sync_en) begin
      hs_cnt++;
      if (hs_first == 0) hs_first = cyc;
    end
    if (int'(bus.active_line) > al_max)
      al_max = int'(bus.active_line);
  endtask

  task automatic go_to(input int target);
    while (t < target) step();
  endtask

  task automatic chk_rst_vals(input string p);
    chk({p, "_vsync"}, 32'(bus.v_sync), 1);
    chk({p, "_hse"}, 32'(bus.h_sync_en), 0);
    chk({p, "_ls"}, 32'(bus.line_start), 0);
    chk({p, "_fs"}, 32'(bus.frame_start), 0);
    chk({p, "_al"}, 32'(bus.active_line), 0);
    chk({p, "_fc"}, 32'(bus.frame_count), 0);
    chk({p, "_paused"}, 32'(bus.paused), 1);
  endtask

  initial begin
    bus.enable    = 1'b1;
    bus.pause_req = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk_rst_vals("rst");

    @(negedge clk);
    reset = 1'b0;
    t = 0;
    go_to(7);
    chk("fs_pre", 32'(bus.frame_start), 0);
    chk("paused_pre", 32'(bus.paused), 1);
    go_to(8);
    chk("fs_first", 32'(bus.frame_start), 1);
    chk("vs_first", 32'(bus.v_sync), 0);
    chk("paused_run", 32'(bus.paused), 0);

    clr();
    go_to(9);
    chk("fs_one", 32'(bus.frame_start), 0);
    go_to(96);
    chk("hs_first", 32'(hs_first), 40);
    chk("hs_cnt", 32'(hs_cnt), 32);
    chk("ls_cnt", 32'(ls_cnt), 4);
    chk("vs_low", 32'(vs_cnt), 16);
    chk("fs_cnt", 32'(fs_cnt), 1);
    chk("al_max", 32'(al_max), 3);
    chk("al_idle", 32'(bus.active_line), 0);
    chk("fc_1", 32'(bus.frame_count), 1);

    go_to(140);
    bus.pause_req = 1'b1;
    go_to(183);
    chk("pz_pre", 32'(bus.paused), 0);
    chk("pz_fc_pre", 32'(bus.frame_count), 1);
    go_to(184);
    chk("pz_in", 32'(bus.paused), 1);
    chk("pz_vs", 32'(bus.v_sync), 1);
    chk("pz_fc", 32'(bus.frame_count), 2);
    chk("pz_fs", 32'(bus.frame_start), 0);
    go_to(200);
    chk("pz_hold", 32'(bus.paused), 1);
    bus.pause_req = 1'b0;
    go_to(207);
    chk("rs_pre", 32'(bus.paused), 1);
    go_to(208);
    chk("rs_fs", 32'(bus.frame_start), 1);
    chk("rs_vs", 32'(bus.v_sync), 0);
    chk("rs_paused", 32'(bus.paused), 0);

    go_to(266);
    bus.enable = 1'b0;
    go_to(271);
    chk("ab_hse_pre", 32'(bus.h_sync_en), 1);
    chk("ab_al_pre", 32'(bus.active_line), 2);
    go_to(272);
    chk("ab_paused", 32'(bus.paused), 1);
    chk("ab_hse", 32'(bus.h_sync_en), 0);
    chk("ab_al", 32'(bus.active_line), 0);
    chk("ab_fc", 32'(bus.frame_count), 2);
    chk("ab_vs", 32'(bus.v_sync), 1);
    bus.enable = 1'b1;
    go_to(280);
    chk("re_fs", 32'(bus.frame_start), 1);
    chk("re_fc", 32'(bus.frame_count), 2);

    go_to(280 + 88 * 253);
    chk("fc_255", 32'(bus.frame_count), 255);
    go_to(280 + 88 * 254);
    chk("fc_wrap", 32'(bus.frame_count), 0);
    chk("fs_wrap", 32'(bus.frame_start), 1);

    go_to(280 + 88 * 255);
    chk("fc_after", 32'(bus.frame_count), 1);
    go_to(280 + 88 * 255 + 8);
    chk("ar_vs_pre", 32'(bus.v_sync), 0);
    #3;
    reset = 1'b1;
    #1;
    chk_rst_vals("arst");
    clr();
    repeat (10) step();
    chk("arst_fs", 32'(fs_cnt), 0);
    chk("arst_ls", 32'(ls_cnt), 0);
    chk("arst_pz", 32'(bus.paused), 1);

    @(negedge clk);
    reset = 1'b0;
    t = 0;
    go_to(7);
    chk("rr_fs_pre", 32'(bus.frame_start), 0);
    go_to(8);
    chk("rr_fs", 32'(bus.frame_start), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_vsync_ctrl.md
VGA_VSYNC_CTRL -- requirements
Module: vga_vsync_ctrl

Interface
REQ-001 SHALL provide parameter H_TOTAL, default 1600: clocks per line; must match the horizontal-sync block.
REQ-002 SHALL provide parameter V_SYNC, default 2: lines with v_sync low.
REQ-003 SHALL provide parameter V_BP, default 29: back-porch lines.
REQ-004 SHALL provide parameter V_ACTIVE, default 480: active lines.
REQ-005 SHALL provide parameter V_FP, default 10: front-porch lines; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP = 521.
REQ-006 SHALL have port clk, input, 1: system clock.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port enable, input, 1: level; 1 = generate frames, 0 = stop at next line boundary.
REQ-009 SHALL have port pause_req, input, 1: level; request to hold after the current frame completes.
REQ-010 SHALL have port v_sync, output, 1: vertical sync, active-low.
REQ-011 SHALL have port h_sync_en, output, 1: active-line enable driving the horizontal block.
REQ-012 SHALL have port line_start, output, 1: one-cycle pulse at the start of each active line.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse on entry to SYNC.
REQ-014 SHALL have port active_line, output, 9: active line index, 0..479.
REQ-015 SHALL have port frame_count, output, 8: completed-frame counter, wraps 255->0.
REQ-016 SHALL have port paused, output, 1: 1 while in IDLE.

Function
REQ-017 SHALL run internal h_count 0..H_TOTAL-1 free-running from reset, independent of enable; line boundary = edge where h_count wraps H_TOTAL-1 -> 0.
REQ-018 SHALL implement FSM states IDLE, SYNC, BACK_PORCH, ACTIVE, FRONT_PORCH; all transitions only at line boundaries.
REQ-019 SHALL track v_line, counting lines within the current state; v_line resets to 0 on each state change.
REQ-020 IDLE -> SYNC SHALL occur when enable=1 and pause_req=0; frame_start pulses on the same edge.
REQ-021 SYNC -> BACK_PORCH after V_SYNC lines; BACK_PORCH -> ACTIVE after V_BP lines; ACTIVE -> FRONT_PORCH after V_ACTIVE lines.
REQ-022 FRONT_PORCH after V_FP lines SHALL increment frame_count and go to SYNC (frame_start pulses), or to IDLE if pause_req=1 or enable=0.
REQ-023 enable=0 in any state SHALL force IDLE at the next line boundary; frame_count does not increment on an aborted frame.
REQ-024 v_sync SHALL be 0 only in SYNC; h_sync_en SHALL be 1 only in ACTIVE; both are registered and change on the line-boundary edge.
REQ-025 line_start SHALL pulse on every line-boundary edge that leaves the FSM in ACTIVE.
REQ-026 active_line SHALL hold 0 outside ACTIVE and increment per active line, 0..V_ACTIVE-1.
REQ-027 pause_req deasserted while in IDLE with enable=1 SHALL resume at the next line boundary, entering SYNC.
REQ-028 Simultaneous enable=0 and pause_req=1: enable dominates (immediate abort to IDLE).

Reset
REQ-029 On reset: state IDLE, h_count 0, v_line 0, v_sync 1, h_sync_en 0, line_start 0, frame_start 0, active_line 0, frame_count 0, paused 1.
REQ-030 Reset mid-frame SHALL return to these values immediately (asynchronous); no pulse may be emitted during reset.

Structure
REQ-031 Timing constants and the FSM state encoding SHALL live in shared package vga_pkg, reused by the horizontal-sync block.
REQ-032 The free-running horizontal counter SHALL be a sub-module, vga_h_counter, with a wrap-pulse output.

Verification
REQ-033 Reset release with enable=1 -> frame_start after 1600 cycles; v_sync low for 3200 cycles; frame period 833,600 cycles.
REQ-034 Steady run -> h_sync_en first high 49,600 cycles after frame_start, high for 768,000 cycles; 480 line_start pulses; active_line ends at 479.
REQ-035 pause_req=1 mid-ACTIVE -> frame completes; IDLE with paused=1 and v_sync=1; pause_req=0 -> SYNC at the next line boundary.
REQ-036 enable=0 at active_line 100 -> IDLE at the next boundary; h_sync_en=0; frame_count unchanged.
REQ-037 256 full frames -> frame_count wraps 255 -> 0.
REQ-038 Async reset asserted mid-SYNC -> all outputs at their reset values within the same cycle; no frame_start pulse.
